// File: rtl/pwm_compare_unit.sv
// PWM compare stage behind a free-running counter: double-buffered duty, start/stop/burst FSM.
// Optional sticky interrupt output is built when PWM_IRQ_EN is defined.
module pwm_compare_unit #(
    parameter int WIDTH = 24,
    parameter int CYC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             wrap_in,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             pwm_out,
    output logic             cycle_done,
`ifdef PWM_IRQ_EN
    output logic             irq,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARM       = 2'd1,
        ST_RUN       = 2'd2,
        ST_STOP_PEND = 2'd3
    } state_t;

    localparam logic [CYC_W-1:0] CYC_ONE  = 1;
    localparam logic [CYC_W-1:0] CYC_ZERO = 0;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] duty_shadow;
    logic [WIDTH-1:0] duty_active;
    logic [WIDTH-1:0] duty_eff;
    logic [CYC_W-1:0] ncyc;
    logic [CYC_W-1:0] cyc_cnt;
    logic [CYC_W-1:0] cyc_inc;
    logic             pol;
    logic             ctrl_wr;
    logic             start;
    logic             stop;
    logic             running;
    logic             running_next;
    logic             period_end;
    logic             burst_end;
    logic             pwm_next;

    assign ctrl_wr    = wr_en && (wr_addr == 2'd2);
    assign start      = ctrl_wr && wr_data[0];
    assign stop       = ctrl_wr && wr_data[1];
    assign running    = (state == ST_RUN) || (state == ST_STOP_PEND);
    assign period_end = running && wrap_in;
    assign cyc_inc    = cyc_cnt + CYC_ONE;
    assign burst_end  = period_end && (ncyc != CYC_ZERO) && (cyc_inc == ncyc);
    assign busy       = (state != ST_IDLE);

    // At a wrap the new period begins with cnt_in=0, so its first compare must
    // already use the duty being promoted, not the outgoing one.
    assign duty_eff = wrap_in ? duty_shadow : duty_active;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start && !stop) state_next = ST_ARM;
            end
            ST_ARM: begin
                if (stop)         state_next = ST_IDLE;
                else if (wrap_in) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (burst_end) state_next = ST_IDLE;
                else if (stop) state_next = ST_STOP_PEND;
            end
            ST_STOP_PEND: begin
                if (wrap_in) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign running_next = (state_next == ST_RUN) || (state_next == ST_STOP_PEND);
    assign pwm_next     = running_next ? ((cnt_in < duty_eff) ^ pol) : pol;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_shadow <= '0;
            ncyc        <= '0;
            pol         <= 1'b0;
        end else if (wr_en) begin
            case (wr_addr)
                2'd0:    duty_shadow <= wr_data;
                2'd1:    ncyc        <= wr_data[CYC_W-1:0];
                2'd2:    pol         <= wr_data[2];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_active <= '0;
            cyc_cnt     <= '0;
            pwm_out     <= 1'b0;
            cycle_done  <= 1'b0;
        end else begin
            if ((state != ST_IDLE) && wrap_in) duty_active <= duty_shadow;
            if ((state == ST_IDLE) && start && !stop) cyc_cnt <= '0;
            else if (period_end)                      cyc_cnt <= cyc_inc;
            pwm_out    <= pwm_next;
            cycle_done <= period_end;
        end
    end

`ifdef PWM_IRQ_EN
    logic irq_clr;
    assign irq_clr = ctrl_wr && wr_data[3];

    // Burst completion always coincides with a period end, so one set term covers both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          irq <= 1'b0;
        else if (period_end) irq <= 1'b1;
        else if (irq_clr)    irq <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_pwm_compare_unit.sv
// Self-checking bench for pwm_compare_unit: directed scenarios plus randomized rounds,
// every output checked each cycle against a period-level behavioural model.
module tb_pwm_compare_unit;

    localparam int WIDTH = 24;
    localparam int CYC_W = 16;
    localparam logic [WIDTH-1:0] MAXV = '1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] cnt_in;
    logic             wrap_in;
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             pwm_out;
    logic             cycle_done;
    logic             busy;
`ifdef PWM_IRQ_EN
    logic             irq;
`endif

    pwm_compare_unit #(.WIDTH(WIDTH), .CYC_W(CYC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cnt_in     (cnt_in),
        .wrap_in    (wrap_in),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .pwm_out    (pwm_out),
        .cycle_done (cycle_done),
`ifdef PWM_IRQ_EN
        .irq        (irq),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cycle_no = 0;

    // Upstream counter: index 0 is the wrap; "hi" mode maps the other indices to the top of the range.
    int up_per = 16;
    int up_idx = 5;
    bit up_hi  = 1'b0;

    // Model: phase 0 idle, 1 waiting for alignment, 2 running, 3 finishing last period.
    int               m_phase;
    int               m_periods;
    logic [WIDTH-1:0] m_shadow;
    logic [WIDTH-1:0] m_duty;
    int               m_ncyc;
    logic             m_pol;
    logic             exp_pwm;
    logic             exp_done;
    logic             exp_busy;
`ifdef PWM_IRQ_EN
    logic             exp_irq;
`endif

    int seen_high;
    int seen_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle_no, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_periods = 0;
        m_shadow  = '0;
        m_duty    = '0;
        m_ncyc    = 0;
        m_pol     = 1'b0;
`ifdef PWM_IRQ_EN
        exp_irq   = 1'b0;
`endif
    endtask

    function automatic logic [WIDTH-1:0] up_val();
        if (up_idx == 0) return '0;
        if (up_hi)       return MAXV - WIDTH'(up_per - 1 - up_idx);
        return WIDTH'(up_idx);
    endfunction

    task automatic model_step(input logic [WIDTH-1:0] cnt, input logic wrap, input logic wen,
                              input logic [1:0] addr, input logic [WIDTH-1:0] data);
        bit ctrl, start, stop;
        int nxt;
        ctrl  = wen && (addr == 2'd2);
        start = ctrl && data[0];
        stop  = ctrl && data[1];
        exp_done = (m_phase >= 2) && wrap;
        if (wrap && m_phase != 0) m_duty = m_shadow;
        nxt = m_phase;
        case (m_phase)
            0: if (start && !stop) begin nxt = 1; m_periods = 0; end
            1: if (stop) nxt = 0; else if (wrap) nxt = 2;
            2: begin
                if (wrap) begin
                    m_periods = (m_periods + 1) % (1 << CYC_W);
                    if (m_ncyc != 0 && m_periods == m_ncyc) nxt = 0;
                    else if (stop) nxt = 3;
                end else if (stop) nxt = 3;
            end
            default: if (wrap) nxt = 0;
        endcase
        exp_pwm  = (nxt >= 2) ? ((cnt < m_duty) ^ m_pol) : m_pol;
        exp_busy = (nxt != 0);
`ifdef PWM_IRQ_EN
        if (exp_done) exp_irq = 1'b1;
        else if (ctrl && data[3]) exp_irq = 1'b0;
`endif
        if (wen && addr == 2'd0) m_shadow = data;
        if (wen && addr == 2'd1) m_ncyc = int'(data[CYC_W-1:0]);
        if (ctrl) m_pol = data[2];
        m_phase = nxt;
    endtask

    task automatic tick(input logic w_en, input logic [1:0] addr, input logic [WIDTH-1:0] data);
        cnt_in  = up_val();
        wrap_in = (up_idx == 0);
        wr_en   = w_en;
        wr_addr = addr;
        wr_data = data;
        model_step(cnt_in, wrap_in, w_en, addr, data);
        up_idx = (up_idx + 1) % up_per;
        @(posedge clk);
        #1;
        cycle_no++;
        check("pwm_out", 32'(pwm_out), 32'(exp_pwm));
        check("cycle_done", 32'(cycle_done), 32'(exp_done));
        check("busy", 32'(busy), 32'(exp_busy));
`ifdef PWM_IRQ_EN
        check("irq", 32'(irq), 32'(exp_irq));
`endif
        seen_high += int'(pwm_out === 1'b1);
        seen_done += int'(cycle_done === 1'b1);
        wr_en = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 2'd0, '0);
    endtask

    task automatic to_wrap();
        for (int i = 0; i < 64 && up_idx != 0; i++) tick(1'b0, 2'd0, '0);
    endtask

    task automatic clear_seen();
        seen_high = 0;
        seen_done = 0;
    endtask

    initial begin
        logic [WIDTH-1:0] d;
        logic             p;
        bit               found;
        rst_n = 1'b0;
        cnt_in = '0; wrap_in = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        model_reset();
        clear_seen();
        repeat (2) @(posedge clk);
        #1;
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_done", 32'(cycle_done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Basic PWM, duty 4 over a 16-count period
        tick(1'b1, 2'd0, 24'd4);
        tick(1'b1, 2'd2, 24'd1);
        idle_ticks(40);
        clear_seen();
        idle_ticks(32);
        check("basic_high", seen_high, 8);
        check("basic_done", seen_done, 2);

        // Shadow write coinciding with a wrap: one more period at 4, then 8
        to_wrap();
        clear_seen();
        tick(1'b1, 2'd0, 24'd8);
        idle_ticks(15);
        check("shadow_old_high", seen_high, 4);
        clear_seen();
        idle_ticks(16);
        check("shadow_new_high", seen_high, 8);
        check("shadow_new_done", seen_done, 1);

        // Stop mid-period, then finish
        idle_ticks(5);
        tick(1'b1, 2'd2, 24'd2);
        check("stop_pend_busy", 32'(busy), 32'd1);
        idle_ticks(20);
        check("stop_idle", 32'(busy), 32'd0);

        // Burst of 3 periods
        tick(1'b1, 2'd1, 24'd3);
        tick(1'b1, 2'd0, 24'd2);
        clear_seen();
        tick(1'b1, 2'd2, 24'd1);
        idle_ticks(80);
        check("burst_done", seen_done, 3);
        check("burst_busy", 32'(busy), 32'd0);
        check("burst_pwm", 32'(pwm_out), 32'd0);

        // Inverted polarity with zero duty, stop, then START+STOP from idle
        tick(1'b1, 2'd1, 24'd0);
        tick(1'b1, 2'd0, 24'd0);
        tick(1'b1, 2'd2, 24'd5);
        idle_ticks(20);
        clear_seen();
        idle_ticks(16);
        check("pol_high", seen_high, 16);
        tick(1'b1, 2'd2, 24'd6);
        idle_ticks(20);
        check("pol_stop_idle", 32'(busy), 32'd0);
        tick(1'b1, 2'd2, 24'd7);
        check("start_stop_idle", 32'(busy), 32'd0);
        idle_ticks(3);
        tick(1'b1, 2'd2, 24'd0);

        // Maximum duty against counts at the top of the range
        up_hi = 1'b1; up_per = 4; up_idx = 1;
        tick(1'b1, 2'd0, MAXV);
        tick(1'b1, 2'd2, 24'd1);
        idle_ticks(12);
        clear_seen();
        idle_ticks(8);
        check("maxduty_high", seen_high, 6);
        tick(1'b1, 2'd2, 24'd2);
        idle_ticks(10);
        up_hi = 1'b0; up_per = 16; up_idx = 1;

        // Randomized rounds
        for (int r = 0; r < 6; r++) begin
            up_per = $urandom_range(3, 40);
            up_idx = 1;
            case ($urandom_range(0, 2))
                0:       d = '0;
                1:       d = MAXV;
                default: d = WIDTH'($urandom_range(0, up_per + 2));
            endcase
            p = 1'($urandom_range(0, 1));
            tick(1'b1, 2'd1, WIDTH'($urandom_range(0, 4)));
            tick(1'b1, 2'd0, d);
            tick(1'b1, 2'd2, {21'd0, p, 2'b01});
            for (int i = 0; i < 120; i++) begin
                case ($urandom_range(0, 59))
                    0, 1, 2: tick(1'b1, 2'd0, WIDTH'($urandom_range(0, up_per + 1)));
                    3:       tick(1'b1, 2'd2, {20'd0, 1'($urandom_range(0, 1)), p, 2'b10});
                    4:       tick(1'b1, 2'd2, {20'd0, 1'($urandom_range(0, 1)), p, 2'b01});
                    5:       tick(1'b1, 2'd3, WIDTH'($urandom));
                    default: tick(1'b0, 2'd0, '0);
                endcase
            end
            tick(1'b1, 2'd2, {21'd0, p, 2'b10});
            idle_ticks(up_per * 2 + 2);
            check("rand_end_idle", 32'(busy), 32'd0);
        end
        up_per = 16; up_idx = 1;

        // Asynchronous reset in the middle of a high phase
        tick(1'b1, 2'd1, 24'd0);
        tick(1'b1, 2'd2, 24'd0);
        tick(1'b1, 2'd0, 24'd12);
        tick(1'b1, 2'd2, 24'd1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1'b0, 2'd0, '0);
            found = (pwm_out === 1'b1) && (busy === 1'b1);
        end
        check("rst_found_high", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pwm", 32'(pwm_out), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(cycle_done), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        idle_ticks(20);
        check("post_rst_idle", 32'(busy), 32'd0);

`ifdef PWM_IRQ_EN
        tick(1'b1, 2'd0, 24'd4);
        tick(1'b1, 2'd2, 24'd1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick(1'b0, 2'd0, '0);
            found = (cycle_done === 1'b1);
        end
        check("irq_first_done", 32'(found), 32'd1);
        check("irq_set", 32'(irq), 32'd1);
        idle_ticks(5);
        check("irq_sticky", 32'(irq), 32'd1);
        to_wrap();
        tick(1'b1, 2'd2, 24'd8);
        check("irq_set_wins", 32'(irq), 32'd1);
        idle_ticks(3);
        tick(1'b1, 2'd2, 24'd8);
        check("irq_cleared", 32'(irq), 32'd0);
        tick(1'b1, 2'd2, 24'd2);
        idle_ticks(20);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
